// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Fetch-unit bus bundle: imem request/response, decode output
//               and branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            instr_valid;
   logic            instr_ready;
   logic [XLEN-1:0] instr;
   logic [6:0]      opcode;
   logic [XLEN-1:0] instr_pc;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   // Fetch-unit side
   modport master (
      output imem_req_valid,
      output imem_addr,
      output instr_valid,
      output instr,
      output opcode,
      output instr_pc,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   // Memory and decode side
   modport slave (
      input  imem_req_valid,
      input  imem_addr,
      input  instr_valid,
      input  instr,
      input  opcode,
      input  instr_pc,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data,
      output instr_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : RV32 front end. Owns the PC, issues one word fetch at a time
//               and buffers a single instruction for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   instr_fetch_unit_if.master bus
);

   localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(4);
   localparam logic [XLEN-1:0] c_PC_RESET = {RESET_PC[XLEN-1:2], 2'b00};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] w_pc_nxt;
   logic            r_kill;
   logic            w_kill_nxt;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_instr_pc;
   logic            w_load_buf;

   logic            w_req_hs;
   logic            w_dec_hs;
   logic [XLEN-1:0] w_redir_pc;

   assign w_req_hs   = (r_state == S_REQ)  && bus.imem_req_ready;
   assign w_dec_hs   = (r_state == S_HOLD) && bus.instr_ready;
   assign w_redir_pc = {bus.redirect_pc[XLEN-1:2], 2'b00};

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_kill_nxt  = r_kill;
      w_load_buf  = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_state_nxt = S_REQ;
         end

         S_REQ: begin
            if (w_req_hs) begin
               w_state_nxt = S_WAIT;
               // Old-address request already left; its reply must be dropped.
               w_kill_nxt  = bus.redirect_valid;
            end
         end

         S_WAIT: begin
            if (bus.imem_rsp_valid) begin
               if (r_kill || bus.redirect_valid) begin
                  w_kill_nxt  = 1'b0;
                  w_state_nxt = S_REQ;
               end else begin
                  w_load_buf  = 1'b1;
                  w_state_nxt = S_HOLD;
               end
            end else if (bus.redirect_valid) begin
               w_kill_nxt = 1'b1;
            end
         end

         S_HOLD: begin
            if (bus.redirect_valid) begin
               w_state_nxt = S_REQ;
            end else if (w_dec_hs) begin
               w_pc_nxt    = r_pc + c_PC_STEP;
               w_state_nxt = S_REQ;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Redirect overrides sequential PC advance in every state.
      if (bus.redirect_valid) begin
         w_pc_nxt = w_redir_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_pc       <= c_PC_RESET;
         r_kill     <= 1'b0;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_kill  <= w_kill_nxt;
         if (w_load_buf) begin
            r_instr    <= bus.imem_rsp_data;
            r_instr_pc <= r_pc;
         end
      end
   end

   assign bus.imem_req_valid = (r_state == S_REQ);
   assign bus.imem_addr      = r_pc;
   assign bus.instr_valid    = (r_state == S_HOLD);
   assign bus.instr          = r_instr;
   assign bus.opcode         = r_instr[6:0];
   assign bus.instr_pc       = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Randomized bench for instr_fetch_unit with a PC-sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   instr_fetch_unit_if #(.XLEN(32)) bus ();

   instr_fetch_unit #(
      .XLEN     (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int          vectors    = 0;
   int          miscompares = 0;
   logic [31:0] model_pc   = 32'h0;
   bit          pend       = 1'b0;
   int          pend_lat   = 0;
   logic [31:0] pend_addr  = 32'h0;
   logic [31:0] last_deliv = 32'h1;
   bit          wrap_seen  = 1'b0;

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_0033;
      if (a == 32'h4) return 32'h0040_2083;
      if (a == 32'h8) return 32'h0020_8463;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
   endfunction

   // Cycle engine: drives random memory/decode/redirect traffic and checks the
   // DUT against the architectural fetch sequence.
   task automatic run_traffic(input int n, input int p_rdy, input int p_irdy,
                              input int p_redir, input int max_lat,
                              input bit force_en, input logic [31:0] force_pc,
                              input bit stop_on_hs, output int delivered);
      bit          chk_req = 1'b0;
      bit          chk_hold = 1'b0;
      logic [31:0] prev_addr = '0;
      logic [31:0] prev_instr = '0;
      logic [31:0] prev_ipc = '0;
      int          idle = 0;
      bit          req_hs, dlv, redir;
      logic [31:0] exp_w;
      delivered = 0;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (chk_req) begin
            vectors++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== prev_addr) begin
               miscompares++;
               $display("FAIL req_stall: valid=%b addr=%h, expected valid=1 addr=%h",
                        bus.imem_req_valid, bus.imem_addr, prev_addr);
            end
         end
         if (chk_hold) begin
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== prev_instr || bus.instr_pc !== prev_ipc) begin
               miscompares++;
               $display("FAIL hold_stable: valid=%b instr=%h pc=%h, expected valid=1 instr=%h pc=%h",
                        bus.instr_valid, bus.instr, bus.instr_pc, prev_instr, prev_ipc);
            end
         end

         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = $urandom;
         if (pend) begin
            if (pend_lat == 0) begin
               bus.imem_rsp_valid = 1'b1;
               bus.imem_rsp_data  = memval(pend_addr);
               pend = 1'b0;
            end else begin
               pend_lat--;
            end
         end

         bus.imem_req_ready = (int'($urandom_range(99)) < p_rdy);
         bus.instr_ready    = (int'($urandom_range(99)) < p_irdy);
         redir              = (int'($urandom_range(99)) < p_redir);
         bus.redirect_pc    = $urandom;
         if (force_en && c == 0) begin
            redir           = 1'b1;
            bus.redirect_pc = force_pc;
         end
         bus.redirect_valid = redir;

         req_hs = bus.imem_req_valid && bus.imem_req_ready;
         dlv    = bus.instr_valid && bus.instr_ready;

         if (req_hs) begin
            vectors++;
            if (bus.imem_addr !== model_pc) begin
               miscompares++;
               $display("FAIL req_addr: got %h expected %h", bus.imem_addr, model_pc);
            end
            if (bus.imem_addr == 32'h0 && last_deliv == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
            pend_lat  = int'($urandom_range(max_lat));
         end

         if (dlv) begin
            vectors++;
            exp_w = memval(model_pc);
            if (bus.instr_pc !== model_pc || bus.instr !== exp_w || bus.opcode !== exp_w[6:0]) begin
               miscompares++;
               $display("FAIL deliver: pc=%h instr=%h op=%b, expected pc=%h instr=%h op=%b",
                        bus.instr_pc, bus.instr, bus.opcode, model_pc, exp_w, exp_w[6:0]);
            end
            delivered++;
            last_deliv = bus.instr_pc;
         end

         if (redir) model_pc = {bus.redirect_pc[31:2], 2'b00};
         else if (dlv) model_pc = model_pc + 32'd4;

         chk_req    = bus.imem_req_valid && !bus.imem_req_ready && !redir;
         prev_addr  = bus.imem_addr;
         chk_hold   = bus.instr_valid && !bus.instr_ready && !redir;
         prev_instr = bus.instr;
         prev_ipc   = bus.instr_pc;

         if (req_hs || dlv) idle = 0;
         else idle++;
         if (idle > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL progress: stalled %0d cycles, expected < 200", idle);
            break;
         end
         if (stop_on_hs && req_hs) break;
      end
   endtask

   task automatic test_reset();
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0 ||
          bus.instr !== 32'h0 || bus.instr_pc !== 32'h0 || bus.opcode !== 7'h0) begin
         miscompares++;
         $display("FAIL reset_outputs: req=%b iv=%b addr=%h instr=%h ipc=%h op=%h, expected all 0",
                  bus.imem_req_valid, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc, bus.opcode);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL first_req: valid=%b addr=%h, expected valid=1 addr=00000000",
                  bus.imem_req_valid, bus.imem_addr);
      end
      model_pc = 32'h0;
   endtask

   task automatic test_stream();
      int d;
      run_traffic(30, 100, 100, 0, 0, 1'b0, 32'h0, 1'b0, d);
      vectors++;
      if (d < 9) begin
         miscompares++;
         $display("FAIL throughput: delivered %0d in 30 cycles, expected >= 9", d);
      end
   endtask

   task automatic test_req_stall();
      int d;
      run_traffic(150, 25, 100, 0, 2, 1'b0, 32'h0, 1'b0, d);
   endtask

   task automatic test_backpressure();
      int d;
      run_traffic(200, 100, 15, 0, 1, 1'b0, 32'h0, 1'b0, d);
   endtask

   task automatic test_redirect();
      int d;
      run_traffic(500, 60, 60, 20, 3, 1'b0, 32'h0, 1'b0, d);
   endtask

   task automatic test_wrap();
      int d;
      wrap_seen = 1'b0;
      run_traffic(40, 100, 100, 0, 0, 1'b1, 32'hFFFF_FFF1, 1'b0, d);
      vectors++;
      if (wrap_seen !== 1'b1) begin
         miscompares++;
         $display("FAIL wrap: no fetch of 00000000 after fffffffc, got wrap_seen=%b expected 1", wrap_seen);
      end
   endtask

   task automatic test_async_reset();
      int d;
      run_traffic(50, 100, 100, 0, 3, 1'b0, 32'h0, 1'b1, d);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'h0 ||
          bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
         miscompares++;
         $display("FAIL async_clear: req=%b iv=%b addr=%h instr=%h ipc=%h, expected 0/0/0/0/0",
                  bus.imem_req_valid, bus.instr_valid, bus.imem_addr, bus.instr, bus.instr_pc);
      end
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      pend = 1'b0;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = memval(pend_addr);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      bus.imem_rsp_valid = 1'b0;
      vectors++;
      if (bus.instr_valid !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_addr !== 32'h0) begin
         miscompares++;
         $display("FAIL late_rsp: iv=%b req=%b addr=%h, expected iv=0 req=1 addr=00000000",
                  bus.instr_valid, bus.imem_req_valid, bus.imem_addr);
      end
      model_pc = 32'h0;
      run_traffic(60, 100, 100, 0, 0, 1'b0, 32'h0, 1'b0, d);
      vectors++;
      if (d < 15) begin
         miscompares++;
         $display("FAIL post_reset: delivered %0d in 60 cycles, expected >= 15", d);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_req_stall();
      test_backpressure();
      test_redirect();
      test_wrap();
      test_async_reset();
      test_redirect();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
